// File: rtl/sys_defs.sv
// Shared system types: physical register index, branch masks, RS entry packet.
// Also provides the default superscalar width `N used by the RS parameter defaults.
// Consumed by rs_bank and its testbench.
`ifndef N
`define N 2
`endif

package sys_defs;

  localparam int B_MASK_W   = 4;
  localparam int PHYS_REG_W = 6;

  typedef logic [PHYS_REG_W-1:0] PHYS_REG_IDX;
  typedef logic [B_MASK_W-1:0]   B_MASK;
  typedef logic [B_MASK_W-1:0]   B_MASK_MASK;

  typedef struct packed {
    logic [7:0]  op;
    PHYS_REG_IDX dest;
    PHYS_REG_IDX Source1;
    logic        Source1_ready;
    PHYS_REG_IDX Source2;
    logic        Source2_ready;
    B_MASK       b_mask;
  } RS_PACKET;

endpackage

// File: rtl/rs_issue_select.sv
// Issue selector: picks up to ISSUE_W requesting entries, highest priority first,
// ties going to the lower index. Purely combinational (0 cycles); no backpressure
// of its own -- the caller decides whether a grant is consumed.
module rs_issue_select #(
  parameter int RS_SZ   = 16,
  parameter int ISSUE_W = 2,
  parameter int PRI_W   = 1
) (
  input  logic [RS_SZ-1:0]              i_req,
  input  logic [RS_SZ-1:0][PRI_W-1:0]   i_pri,
  output logic [ISSUE_W-1:0][RS_SZ-1:0] o_gnt
);

  logic [RS_SZ-1:0] w_avail;
  logic             w_found;
  int               w_best_idx;
  logic [PRI_W-1:0] w_best_pri;

  // Repeated max-search: each port takes the best remaining request, removing it.
  always_comb begin
    w_avail    = i_req;
    o_gnt      = '0;
    w_found    = 1'b0;
    w_best_idx = 0;
    w_best_pri = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      w_found    = 1'b0;
      w_best_idx = 0;
      w_best_pri = '0;
      for (int e = 0; e < RS_SZ; e++) begin
        // Strict '>' keeps the lowest index among equal priorities.
        if (w_avail[e] && (!w_found || (i_pri[e] > w_best_pri))) begin
          w_found    = 1'b1;
          w_best_idx = e;
          w_best_pri = i_pri[e];
        end
      end
      if (w_found) begin
        o_gnt[p][w_best_idx] = 1'b1;
        w_avail[w_best_idx]  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rs_bank.sv
// Reservation station bank: dispatch into free entries, CDB wakeup, branch squash/resolve, issue.
// Latency: dispatch-to-issue >= 1 cycle; wakeup visible to issue the cycle after the broadcast.
// Backpressure: rs_spots credit toward dispatch; issue_ready low holds the entry for reselection.
// Optional RS_AGE_ORDER_EN: oldest-first issue using saturating per-entry age counters.
`ifndef N
`define N 2
`endif

module rs_bank
  import sys_defs::*;
#(
  parameter int RS_SZ   = 16,
  parameter int DISP_W  = `N,
  parameter int CDB_W   = `N,
  parameter int ISSUE_W = `N
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [DISP_W-1:0]                 disp_valid,
  input  RS_PACKET [DISP_W-1:0]             disp_entries,
  output logic [$clog2(DISP_W+1)-1:0]       rs_spots,
  input  logic [CDB_W-1:0]                  cdb_valid,
  input  PHYS_REG_IDX [CDB_W-1:0]           cdb_tags,
  input  B_MASK_MASK                        b_mm_resolve,
  input  logic                              b_mm_mispred,
  input  logic [ISSUE_W-1:0]                issue_ready,
  output logic [ISSUE_W-1:0]                issue_valid,
  output RS_PACKET [ISSUE_W-1:0]            issue_packets,
  output logic [RS_SZ-1:0]                  rs_valid
);

  localparam int SPOT_W = $clog2(DISP_W + 1);
  localparam int AGE_W  = $clog2(RS_SZ);
`ifdef RS_AGE_ORDER_EN
  localparam int PRI_W  = AGE_W;
`else
  localparam int PRI_W  = 1;
`endif

  logic [RS_SZ-1:0]               r_valid;
  RS_PACKET [RS_SZ-1:0]           r_pkt;

  int                             w_free_cnt;
  int                             w_slot;
  logic [RS_SZ-1:0]               w_alloc;
  RS_PACKET [RS_SZ-1:0]           w_cur_pkt;
  RS_PACKET [RS_SZ-1:0]           w_nxt_pkt;
  logic [RS_SZ-1:0]               w_live;
  logic [RS_SZ-1:0]               w_squash;
  logic [RS_SZ-1:0]               w_req;
  logic [RS_SZ-1:0]               w_issued;
  logic [RS_SZ-1:0]               w_nxt_valid;
  logic [RS_SZ-1:0][PRI_W-1:0]    w_pri;
  logic [ISSUE_W-1:0][RS_SZ-1:0]  w_gnt;

  function automatic logic f_cdb_hit(input PHYS_REG_IDX tag,
                                     input logic [CDB_W-1:0] vld,
                                     input PHYS_REG_IDX [CDB_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_W; c++) begin
      if (vld[c] && (tags[c] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Credit from registered occupancy only, so it never depends on this cycle's issue.
  always_comb begin
    w_free_cnt = 0;
    for (int e = 0; e < RS_SZ; e++) begin
      if (!r_valid[e]) w_free_cnt++;
    end
    rs_spots = (w_free_cnt >= DISP_W) ? SPOT_W'(DISP_W) : SPOT_W'(w_free_cnt);
  end

  // Slot k lands in the k-th lowest free entry; entries freed this cycle are not candidates.
  always_comb begin
    w_slot    = 0;
    w_alloc   = '0;
    w_cur_pkt = r_pkt;
    for (int e = 0; e < RS_SZ; e++) begin
      if (!r_valid[e] && (w_slot < DISP_W)) begin
        if (disp_valid[w_slot]) begin
          w_alloc[e]   = 1'b1;
          w_cur_pkt[e] = disp_entries[w_slot];
        end
        w_slot++;
      end
    end
  end

  // Squash covers stored and incoming entries; squashed entries never request issue.
  always_comb begin
    w_live   = r_valid | w_alloc;
    w_squash = '0;
    w_req    = '0;
    for (int e = 0; e < RS_SZ; e++) begin
      w_squash[e] = w_live[e] && b_mm_mispred && (|(w_cur_pkt[e].b_mask & b_mm_resolve));
      w_req[e]    = r_valid[e] && r_pkt[e].Source1_ready && r_pkt[e].Source2_ready && !w_squash[e];
    end
  end

`ifdef RS_AGE_ORDER_EN
  logic [RS_SZ-1:0][AGE_W-1:0] r_age;

  // Age restarts on dispatch and saturates, so equal ages fall back to index order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_age <= '0;
    end else begin
      for (int e = 0; e < RS_SZ; e++) begin
        if (w_alloc[e]) r_age[e] <= '0;
        else if (r_valid[e] && (r_age[e] != {AGE_W{1'b1}})) r_age[e] <= r_age[e] + 1'b1;
      end
    end
  end

  assign w_pri = r_age;
`else
  assign w_pri = '0;
`endif

  rs_issue_select #(
    .RS_SZ   (RS_SZ),
    .ISSUE_W (ISSUE_W),
    .PRI_W   (PRI_W)
  ) u_sel (
    .i_req (w_req),
    .i_pri (w_pri),
    .o_gnt (w_gnt)
  );

  // Port muxing; idle ports carry zero, an entry leaves only on a ready port.
  always_comb begin
    issue_valid   = '0;
    issue_packets = '0;
    w_issued      = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      issue_valid[p] = |w_gnt[p];
      for (int e = 0; e < RS_SZ; e++) begin
        if (w_gnt[p][e]) begin
          issue_packets[p] = r_pkt[e];
          if (issue_ready[p]) w_issued[e] = 1'b1;
        end
      end
    end
  end

  // Next entry state: wakeup and b_mask clear apply to stored and incoming alike; squash dominates.
  always_comb begin
    w_nxt_pkt   = w_cur_pkt;
    w_nxt_valid = '0;
    for (int e = 0; e < RS_SZ; e++) begin
      if (f_cdb_hit(w_cur_pkt[e].Source1, cdb_valid, cdb_tags)) w_nxt_pkt[e].Source1_ready = 1'b1;
      if (f_cdb_hit(w_cur_pkt[e].Source2, cdb_valid, cdb_tags)) w_nxt_pkt[e].Source2_ready = 1'b1;
      if (!b_mm_mispred) w_nxt_pkt[e].b_mask = w_cur_pkt[e].b_mask & ~b_mm_resolve;
      w_nxt_valid[e] = w_live[e] && !w_squash[e] && !w_issued[e];
    end
  end

  // Entry storage; reset drops every entry and any in-flight update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_pkt   <= '0;
    end else begin
      r_valid <= w_nxt_valid;
      r_pkt   <= w_nxt_pkt;
    end
  end

  assign rs_valid = r_valid;

endmodule

// File: tb/tb_rs_bank.sv
// Directed bench for rs_bank (RS_SZ=8, DISP_W=2, CDB_W=2, ISSUE_W=2) with an issue scoreboard.
// Expected issue packets are queued as stimulus makes them issuable and popped at the issue port.
// Expectations hold for both the index-ordered and age-ordered builds.
module tb_rs_bank;
  import sys_defs::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [1:0]           disp_valid;
  RS_PACKET [1:0]       disp_entries;
  logic [1:0]           rs_spots;
  logic [1:0]           cdb_valid;
  PHYS_REG_IDX [1:0]    cdb_tags;
  B_MASK_MASK           b_mm_resolve;
  logic                 b_mm_mispred;
  logic [1:0]           issue_ready;
  logic [1:0]           issue_valid;
  RS_PACKET [1:0]       issue_packets;
  logic [7:0]           rs_valid;

  int total = 0;
  int bad   = 0;
  RS_PACKET q_exp[$];

  rs_bank #(.RS_SZ(8), .DISP_W(2), .CDB_W(2), .ISSUE_W(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .disp_valid    (disp_valid),
    .disp_entries  (disp_entries),
    .rs_spots      (rs_spots),
    .cdb_valid     (cdb_valid),
    .cdb_tags      (cdb_tags),
    .b_mm_resolve  (b_mm_resolve),
    .b_mm_mispred  (b_mm_mispred),
    .issue_ready   (issue_ready),
    .issue_valid   (issue_valid),
    .issue_packets (issue_packets),
    .rs_valid      (rs_valid)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic RS_PACKET mk(input logic [7:0] op, input PHYS_REG_IDX d,
                                  input PHYS_REG_IDX s1, input logic r1,
                                  input PHYS_REG_IDX s2, input logic r2, input B_MASK bm);
    RS_PACKET p;
    p.op = op; p.dest = d;
    p.Source1 = s1; p.Source1_ready = r1;
    p.Source2 = s2; p.Source2_ready = r2;
    p.b_mask = bm;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input int port);
    RS_PACKET exp;
    if (q_exp.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty port=%0d observed_valid=%0b expected=queued_entry", port, issue_valid[port]);
    end else begin
      exp = q_exp.pop_front();
      chk("sb_issue_valid", 64'(issue_valid[port]), 64'd1);
      chk("sb_issue_pkt", 64'(issue_packets[port]), 64'(exp));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; disp_valid = '0; disp_entries = '0; cdb_valid = '0; cdb_tags = '0;
    b_mm_resolve = '0; b_mm_mispred = 1'b0; issue_ready = '0;
    #12;
    chk("rst_spots", 64'(rs_spots), 64'd2);
    chk("rst_valid", 64'(rs_valid), 64'd0);
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    reset = 1'b0;

    // Fill all 8 entries two per cycle with unready sources.
    for (int c = 0; c < 4; c++) begin
      chk("fill_spots", 64'(rs_spots), 64'd2);
      disp_valid = 2'b11;
      disp_entries[0] = mk(8'(2*c), 6'd1, 6'd20, 1'b0, 6'd21, 1'b0, 4'b0);
      disp_entries[1] = mk(8'(2*c+1), 6'd1, 6'd20, 1'b0, 6'd21, 1'b0, 4'b0);
      tick();
    end
    disp_valid = '0; #1;
    chk("full_valid", 64'(rs_valid), 64'hFF);
    chk("full_spots", 64'(rs_spots), 64'd0);
    disp_valid = 2'b11; tick(); disp_valid = '0; #1;
    chk("full_drop_valid", 64'(rs_valid), 64'hFF);
    chk("full_drop_spots", 64'(rs_spots), 64'd0);

    // Reset mid-operation with dispatch and wakeup in flight.
    disp_valid = 2'b11; cdb_valid = 2'b11; cdb_tags[0] = 6'd20; cdb_tags[1] = 6'd21;
    #1 reset = 1'b1; #1;
    chk("midrst_valid", 64'(rs_valid), 64'd0);
    chk("midrst_spots", 64'(rs_spots), 64'd2);
    chk("midrst_issue_valid", 64'(issue_valid), 64'd0);
    tick();
    reset = 1'b0; disp_valid = '0; cdb_valid = '0; #1;
    chk("postrst_valid", 64'(rs_valid), 64'd0);

    // Wakeup of a stored entry: issue only the cycle after the broadcast.
    issue_ready = 2'b11;
    disp_valid = 2'b01; disp_entries[0] = mk(8'h10, 6'd1, 6'd5, 1'b0, 6'd9, 1'b0, 4'b0);
    tick(); disp_valid = '0; #1;
    chk("wake_stored", 64'(rs_valid), 64'h01);
    chk("wake_iv_before", 64'(issue_valid), 64'd0);
    cdb_valid = 2'b11; cdb_tags[0] = 6'd5; cdb_tags[1] = 6'd9;
    q_exp.push_back(mk(8'h10, 6'd1, 6'd5, 1'b1, 6'd9, 1'b1, 4'b0));
    #1;
    chk("wake_iv_same_cycle", 64'(issue_valid), 64'd0);
    tick(); cdb_valid = '0; #1;
    pop_chk(0);
    chk("wake_iv_port1", 64'(issue_valid[1]), 64'd0);
    tick(); #1;
    chk("wake_freed", 64'(rs_valid), 64'd0);

    // Wakeup applied to an entry while it is being dispatched.
    disp_valid = 2'b01; disp_entries[0] = mk(8'h20, 6'd2, 6'd7, 1'b0, 6'd3, 1'b1, 4'b0);
    cdb_valid = 2'b10; cdb_tags[0] = 6'd0; cdb_tags[1] = 6'd7;
    q_exp.push_back(mk(8'h20, 6'd2, 6'd7, 1'b1, 6'd3, 1'b1, 4'b0));
    #1;
    chk("dwake_iv_before", 64'(issue_valid), 64'd0);
    tick(); disp_valid = '0; cdb_valid = '0; #1;
    chk("dwake_stored", 64'(rs_valid), 64'h01);
    pop_chk(0);
    tick(); #1;
    chk("dwake_freed", 64'(rs_valid), 64'd0);

    // Mispredict squashes only the entry depending on the resolving branch.
    issue_ready = 2'b00;
    disp_valid = 2'b11;
    disp_entries[0] = mk(8'h30, 6'd3, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0010);
    disp_entries[1] = mk(8'h31, 6'd4, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0100);
    tick(); disp_valid = '0; #1;
    chk("sq_pre_iv", 64'(issue_valid), 64'b11);
    b_mm_resolve = 4'b0010; b_mm_mispred = 1'b1; #1;
    chk("sq_iv", 64'(issue_valid), 64'b01);
    chk("sq_port0_op", 64'(issue_packets[0].op), 64'h31);
    chk("sq_port1_zero", 64'(issue_packets[1]), 64'd0);
    tick(); b_mm_resolve = '0; b_mm_mispred = 1'b0; #1;
    chk("sq_valid", 64'(rs_valid), 64'b0010);
    issue_ready = 2'b01;
    q_exp.push_back(mk(8'h31, 6'd4, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0100));
    #1;
    pop_chk(0);
    tick(); issue_ready = 2'b00; #1;
    chk("sq_drained", 64'(rs_valid), 64'd0);

    // Correct prediction: both survive and the resolved bit clears.
    disp_valid = 2'b11;
    disp_entries[0] = mk(8'h30, 6'd3, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0010);
    disp_entries[1] = mk(8'h31, 6'd4, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0100);
    tick(); disp_valid = '0;
    b_mm_resolve = 4'b0010; b_mm_mispred = 1'b0;
    tick(); b_mm_resolve = '0; #1;
    chk("res_valid", 64'(rs_valid), 64'b0011);
    chk("res_bmask0", 64'(issue_packets[0].b_mask), 64'd0);
    chk("res_bmask1", 64'(issue_packets[1].b_mask), 64'b0100);
    issue_ready = 2'b11;
    q_exp.push_back(mk(8'h30, 6'd3, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0000));
    q_exp.push_back(mk(8'h31, 6'd4, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0100));
    #1;
    pop_chk(0);
    pop_chk(1);
    tick(); issue_ready = 2'b00; #1;
    chk("res_drained", 64'(rs_valid), 64'd0);

    // Three ready entries, only port 0 accepting.
    disp_valid = 2'b11;
    disp_entries[0] = mk(8'h40, 6'd5, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0);
    disp_entries[1] = mk(8'h41, 6'd6, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0);
    tick();
    disp_valid = 2'b01;
    disp_entries[0] = mk(8'h42, 6'd7, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0);
    tick(); disp_valid = '0; #1;
    chk("bp_valid", 64'(rs_valid), 64'b0111);
    chk("bp_iv", 64'(issue_valid), 64'b11);
    issue_ready = 2'b01;
    q_exp.push_back(mk(8'h40, 6'd5, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0));
    #1;
    pop_chk(0);
    tick(); #1;
    chk("bp_remaining", 64'(rs_valid), 64'b0110);
    issue_ready = 2'b11;
    q_exp.push_back(mk(8'h41, 6'd6, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0));
    q_exp.push_back(mk(8'h42, 6'd7, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0));
    #1;
    pop_chk(0);
    pop_chk(1);
    tick(); issue_ready = 2'b00; #1;
    chk("bp_drained", 64'(rs_valid), 64'd0);
    chk("sb_leftover", 64'(q_exp.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_bank.md
RS_BANK -- requirements
Module: rs_bank

Interface
REQ-001 SHALL have parameter RS_SZ, default 16, number of entries.
REQ-002 SHALL have parameter DISP_W, default `N, dispatch slots per cycle.
REQ-003 SHALL have parameter CDB_W, default `N, broadcast tag channels.
REQ-004 SHALL have parameter ISSUE_W, default `N, issue ports.
REQ-005 SHALL have these ports (name, direction, width, meaning):
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- disp_valid  in  DISP_W  thermometer-coded dispatch request.
- disp_entries  in  DISP_W x RS_PACKET  incoming entries.
- rs_spots  out  clog2(DISP_W+1)  free-entry credit.
- cdb_valid  in  CDB_W  tag broadcast valid.
- cdb_tags  in  CDB_W x PHYS_REG_IDX  broadcast tags.
- b_mm_resolve  in  B_MASK_W  one-hot resolving branch.
- b_mm_mispred  in  1  resolving branch mispredicted.
- issue_ready  in  ISSUE_W  FU port accepts this cycle.
- issue_valid  out  ISSUE_W  port carries an entry.
- issue_packets  out  ISSUE_W x RS_PACKET  issued entries.
- rs_valid  out  RS_SZ  per-entry valid, for debug/SVA.

Function
REQ-006 SHALL drive rs_spots = min(count of clear rs_valid bits, DISP_W), computed from registered state only.
REQ-007 SHALL write dispatch slot k into the k-th lowest-index free entry at the clock edge; slots with k >= rs_spots are dropped.
REQ-008 SHALL not reuse an entry freed by issue or squash in the current cycle before the next cycle.
REQ-009 SHALL, for a valid entry whose Source1/Source2 matches any valid cdb_tags, set Source1_ready/Source2_ready at the next edge.
REQ-010 SHALL apply the same CDB match to entries being dispatched, so they are written already ready.
REQ-011 SHALL treat an entry as issuable when valid and both source-ready bits are set in registered state; a wakeup takes effect no earlier than the following cycle.
REQ-012 SHALL assign up to ISSUE_W issuable entries to ports 0..ISSUE_W-1 in selection order, each entry to at most one port.
REQ-013 SHALL clear an entry at the edge where its port has issue_valid && issue_ready; if issue_ready is low, the entry stays and is reselected.
REQ-014 SHALL, when b_mm_mispred and (b_mask & b_mm_resolve) != 0, invalidate the entry at the next edge, including entries being dispatched that cycle.
REQ-015 SHALL suppress issue_valid for any entry squashed in the same cycle.
REQ-016 SHALL, when !b_mm_mispred, clear the b_mm_resolve bit in b_mask of all surviving and incoming entries at the next edge.
REQ-017 SHALL give squash priority over issue, wakeup and b_mask clear on the same entry.
REQ-018 SHALL drive issue_packets to '0 on ports with issue_valid low.

Reset
REQ-019 SHALL, while reset is high, clear all rs_valid, drive issue_valid to 0, and drive rs_spots = min(RS_SZ, DISP_W).
REQ-020 SHALL discard all in-flight dispatch, wakeup and issue on reset assertion mid-operation; no entry survives.

Configuration
REQ-021 SHALL, with RS_AGE_ORDER_EN defined, keep a per-entry age counter of width clog2(RS_SZ) and select oldest-first, with ties broken by lower index.
REQ-022 SHALL, without RS_AGE_ORDER_EN, select by lowest entry index and contain no age state.

Structure
REQ-023 SHALL take RS_PACKET, B_MASK, B_MASK_MASK and PHYS_REG_IDX from the shared sys_defs package; no new typedefs.
REQ-024 SHALL implement issue selection in a sub-module rs_issue_select (valid/priority vector in, ISSUE_W one-hot grants out), reused in both configuration modes.

Verification (RS_SZ=8, DISP_W=2, CDB_W=2, ISSUE_W=2)
REQ-025 SHALL cover: after reset, rs_spots=2; dispatch 2 entries per cycle for 4 cycles, then rs_spots=0 and a further disp_valid=2'b11 is dropped.
REQ-026 SHALL cover: an entry with Source1=5 and Source2=9 not ready; cdb_tags={5,9} valid in cycle t, then issue_valid[0]=1 in cycle t+1 and not in cycle t.
REQ-027 SHALL cover: dispatch an entry with Source1=7 while cdb_tags[1]=7 is valid, then the entry is stored ready and issues the next cycle.
REQ-028 SHALL cover: entries with b_mask 4'b0010 and 4'b0100; b_mm_resolve=4'b0010 with mispred=1, then only the first is invalidated and issue_valid for it is 0 in that cycle.
REQ-029 SHALL cover: the same setup with mispred=0, then both survive and the first has b_mask=0 next cycle.
REQ-030 SHALL cover: 3 ready entries with issue_ready=2'b01, then only port 0 frees an entry; the other two remain valid; with RS_AGE_ORDER_EN the oldest entry issues first.
